// File: rtl/aemb2_dwb_pkg.sv
// Shared definitions for the AEMB2 data-bus SRAM responder: FSM encoding and lane geometry.
package aemb2_dwb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } dwb_state_e;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

endpackage

// File: rtl/aemb2_dwb_sram_bank.sv
// Single-port 2**DEPTH_LOG x 32 synchronous RAM with per-lane write enables and a registered read port.
module aemb2_dwb_sram_bank
  import aemb2_dwb_pkg::*;
#(
  parameter int DEPTH_LOG = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DEPTH_LOG-1:0]       addr_i,
  input  logic [LANES-1:0]           we_i,
  input  logic [LANES*LANE_W-1:0]    wdata_i,
  input  logic                       re_i,
  output logic [LANES*LANE_W-1:0]    rdata_o
);

  logic [LANES*LANE_W-1:0] mem_q [2**DEPTH_LOG];
  logic [LANES*LANE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we_i[k]) begin
        mem_q[addr_i][k*LANE_W +: LANE_W] <= wdata_i[k*LANE_W +: LANE_W];
      end
    end
  end

  // Only the output register is cleared; array contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/aemb2_dwb_sram.sv
// Wishbone data-bus SRAM responder for the AEMB2 data side.
// Wait states (WAIT parameter) are built only when AEMB2_DWB_SRAM_WAIT_EN is defined.
module aemb2_dwb_sram
  import aemb2_dwb_pkg::*;
#(
  parameter int AEMB_DWB  = 32,
  parameter int DEPTH_LOG = 10,
  parameter int WAIT      = 0
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic [AEMB_DWB-1:2] dwb_adr_i,
  input  logic [3:0]          dwb_sel_i,
  input  logic                dwb_stb_i,
  input  logic                dwb_cyc_i,
  input  logic                dwb_wre_i,
  input  logic                dwb_tag_i,
  input  logic [31:0]         dwb_dat_i,
  output logic [31:0]         dwb_dat_o,
  output logic                dwb_ack_o
);

  dwb_state_e           state_q, state_d;
  logic                 req;
  logic                 enter_ack;
  logic                 ack_q;
  logic [LANES-1:0]     we;
  logic                 re;
  logic [DEPTH_LOG-1:0] index;
  logic                 unused_ok;

  assign req       = dwb_stb_i & dwb_cyc_i;
  assign index     = dwb_adr_i[DEPTH_LOG+1:2];
  assign unused_ok = ^{dwb_tag_i, dwb_adr_i[AEMB_DWB-1:DEPTH_LOG+2]};

`ifdef AEMB2_DWB_SRAM_WAIT_EN
  localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  localparam int UNUSED_WAIT = WAIT;
`endif

  always_comb begin
    state_d   = state_q;
    enter_ack = 1'b0;
`ifdef AEMB2_DWB_SRAM_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
`ifdef AEMB2_DWB_SRAM_WAIT_EN
          if (WAIT == 0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT - 1);
          end
`else
          state_d   = ST_ACK;
          enter_ack = 1'b1;
`endif
        end
      end
`ifdef AEMB2_DWB_SRAM_WAIT_EN
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      // A still-high strobe here belongs to the finished transfer.
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= enter_ack;
    end
  end

  // Enables are masked by reset so a transfer caught by reset never commits.
  assign we = (enter_ack & dwb_wre_i & ~grst) ? dwb_sel_i : '0;
  assign re = enter_ack & ~dwb_wre_i & ~grst;

  aemb2_dwb_sram_bank #(
    .DEPTH_LOG(DEPTH_LOG)
  ) u_bank (
    .clk    (gclk),
    .rst    (grst),
    .addr_i (index),
    .we_i   (we),
    .wdata_i(dwb_dat_i),
    .re_i   (re),
    .rdata_o(dwb_dat_o)
  );

  assign dwb_ack_o = ack_q;

endmodule
